video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_if.sv | 44 ++++
 rtl/video_timing_gen.sv | 181 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
//
// Raster timing bundle between the timing generator and the TMDS encoder side.
//
//   ce            clock enable into the generator (all state advances on ce=1)
//   hcount        presented pixel column
//   vcount        presented line
//   VDE           video data enable
//   CD            {vsync, hsync} control pair
//   line_start    strobe at hcount==0
//   frame_start   strobe at hcount==0 && vcount==0
//   frame_switch  animation toggle
//   frame_count   completed frames, wraps at 2^16
//
// Modports: master = generator (drives timing, receives ce),
//           slave  = consumer  (drives ce, receives timing).
// -----------------------------------------------------------------------------
interface video_timing_gen_if #(
    parameter int HC_W = 11,
    parameter int VC_W = 10
);
    logic            ce;
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            VDE;
    logic [1:0]      CD;
    logic            line_start;
    logic            frame_start;
    logic            frame_switch;
    logic [15:0]     frame_count;

    modport master (
        input  ce,
        output hcount, vcount, VDE, CD,
        output line_start, frame_start, frame_switch, frame_count
    );

    modport slave (
        output ce,
        input  hcount, vcount, VDE, CD,
        input  line_start, frame_start, frame_switch, frame_count
    );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator for a TMDS encoder. Two free-running
// counters (h_cnt, v_cnt) walk the full raster; every output is a registered
// decode of that position, so hcount/vcount and all timing signals leave this
// block mutually aligned with one cycle of latency.
//
// Ports:
//   pixclk  in   pixel clock (single domain)
//   reset   in   synchronous active-low reset, sampled on pixclk rising edge
//   vt      master modport of video_timing_gen_if:
//             ce in; hcount, vcount, VDE, CD={vsync,hsync}, line_start,
//             frame_start, frame_switch, frame_count out
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int ANIM_DIV  = 11,
    parameter int HC_W      = 11,
    parameter int VC_W      = 10
) (
    input  logic               pixclk,
    input  logic               reset,
    video_timing_gen_if.master vt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AC_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // Configuration errors stop elaboration rather than producing a raster
    // that silently truncates.
    if (H_TOTAL > (64'd1 << HC_W)) begin : g_h_total_err
        $error("video_timing_gen: H_TOTAL %0d does not fit in HC_W=%0d", H_TOTAL, HC_W);
    end
    if (V_TOTAL > (64'd1 << VC_W)) begin : g_v_total_err
        $error("video_timing_gen: V_TOTAL %0d does not fit in VC_W=%0d", V_TOTAL, VC_W);
    end
    if (ANIM_DIV < 1) begin : g_anim_div_err
        $error("video_timing_gen: ANIM_DIV must be >= 1 (got %0d)", ANIM_DIV);
    end

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

    // Region boundaries are one bit wider than the counters: with a zero back
    // porch the sync end equals 2^W and would wrap to 0 at counter width.
    localparam logic [HC_W:0] H_ACT_END  = (HC_W + 1)'(H_ACTIVE);
    localparam logic [HC_W:0] H_SYNC_BEG = (HC_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [HC_W:0] H_SYNC_END = (HC_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W:0] V_ACT_END  = (VC_W + 1)'(V_ACTIVE);
    localparam logic [VC_W:0] V_SYNC_BEG = (VC_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [VC_W:0] V_SYNC_END = (VC_W + 1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [AC_W-1:0] ANIM_LAST = AC_W'(ANIM_DIV - 1);
    localparam logic [1:0]      CD_IDLE   = {~VSYNC_POL, ~HSYNC_POL};

    // Raster counters
    logic [HC_W-1:0] h_cnt_q, h_cnt_d;
    logic [VC_W-1:0] v_cnt_q, v_cnt_d;

    // Registered outputs
    logic [HC_W-1:0] hcount_q, hcount_d;
    logic [VC_W-1:0] vcount_q, vcount_d;
    logic            vde_q, vde_d;
    logic [1:0]      cd_q, cd_d;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_switch_q, frame_switch_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [AC_W-1:0] anim_cnt_q, anim_cnt_d;

    // Position decode of the counters (what will be presented next edge)
    logic h_active, v_active, h_sync_on, v_sync_on;
    logic h_wrap, v_wrap, frame_end;

    assign h_active  = {1'b0, h_cnt_q} < H_ACT_END;
    assign v_active  = {1'b0, v_cnt_q} < V_ACT_END;
    assign h_sync_on = ({1'b0, h_cnt_q} >= H_SYNC_BEG) && ({1'b0, h_cnt_q} < H_SYNC_END);
    assign v_sync_on = ({1'b0, v_cnt_q} >= V_SYNC_BEG) && ({1'b0, v_cnt_q} < V_SYNC_END);
    assign h_wrap    = (h_cnt_q == H_LAST);
    assign v_wrap    = (v_cnt_q == V_LAST);

    // Frame end is judged on the presented position, so the count and the
    // animation toggle change on the same edge that presents frame_start.
    assign frame_end = (hcount_q == H_LAST) && (vcount_q == V_LAST);

    always_comb begin
        // NOTE: every *_d gets its hold value first; without a default on every
        // path a combinational block infers latches.
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        hcount_d       = hcount_q;
        vcount_d       = vcount_q;
        vde_d          = vde_q;
        cd_d           = cd_q;
        line_start_d   = line_start_q;
        frame_start_d  = frame_start_q;
        frame_switch_d = frame_switch_q;
        frame_count_d  = frame_count_q;
        anim_cnt_d     = anim_cnt_q;

        // With ce low everything holds, strobes included; consumers
        // qualify strobes with ce.
        if (vt.ce) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end

            hcount_d      = h_cnt_q;
            vcount_d      = v_cnt_q;
            vde_d         = h_active && v_active;
            cd_d          = {v_sync_on ? VSYNC_POL : ~VSYNC_POL,
                             h_sync_on ? HSYNC_POL : ~HSYNC_POL};
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

            if (frame_end) begin
                frame_count_d = frame_count_q + 16'd1;
                if (anim_cnt_q == ANIM_LAST) begin
                    anim_cnt_d     = '0;
                    frame_switch_d = ~frame_switch_q;
                end else begin
                    anim_cnt_d = anim_cnt_q + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    // Reset is checked before ce so an asserted reset wins even during a stall,
    // and a sync pulse in progress is cut off immediately.
    always_ff @(posedge pixclk) begin
        if (!reset) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            hcount_q       <= '0;
            vcount_q       <= '0;
            vde_q          <= 1'b0;
            cd_q           <= CD_IDLE;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_switch_q <= 1'b0;
            frame_count_q  <= '0;
            anim_cnt_q     <= '0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            hcount_q       <= hcount_d;
            vcount_q       <= vcount_d;
            vde_q          <= vde_d;
            cd_q           <= cd_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            frame_switch_q <= frame_switch_d;
            frame_count_q  <= frame_count_d;
            anim_cnt_q     <= anim_cnt_d;
        end
    end

    assign vt.hcount       = hcount_q;
    assign vt.vcount       = vcount_q;
    assign vt.VDE          = vde_q;
    assign vt.CD           = cd_q;
    assign vt.line_start   = line_start_q;
    assign vt.frame_start  = frame_start_q;
    assign vt.frame_switch = frame_switch_q;
    assign vt.frame_count  = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Three generators share clock, reset and ce:
//   A: default 800x600 timing
//   B: small raster H 4/1/2/1, V 3/1/1/1, positive syncs, ANIM_DIV=2
//   C: same small raster, ANIM_DIV=1, counters exactly as wide as the totals
// Stimulus pushes the expected presented state per generator into a queue; a
// monitor pops and compares one entry per generator after every clock edge.
// The reference model tracks a linear pixel index and a completed-frame count
// and derives every output arithmetically from them.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int div;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        vde;
        logic [1:0]  cd;
        logic        ls;
        logic        fs;
        logic        fsw;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen_if #(.HC_W(11), .VC_W(10)) vt_a ();
    video_timing_gen_if #(.HC_W(11), .VC_W(10)) vt_b ();
    video_timing_gen_if #(.HC_W(3),  .VC_W(3))  vt_c ();

    video_timing_gen u_a (
        .pixclk (clk),
        .reset  (rst_n),
        .vt     (vt_a)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .ANIM_DIV(2),
        .HC_W(11), .VC_W(10)
    ) u_b (
        .pixclk (clk),
        .reset  (rst_n),
        .vt     (vt_b)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .ANIM_DIV(1),
        .HC_W(3), .VC_W(3)
    ) u_c (
        .pixclk (clk),
        .reset  (rst_n),
        .vt     (vt_c)
    );

    // ---------------------------------------------------------------- checks
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    cfg_t cfg    [3];
    int   pres   [3];   // linear index of the presented pixel
    int   nxt    [3];   // linear index presented after the next ce edge
    int   frames [3];   // frames completed since reset
    bit   rst_st [3];   // presenting the reset state

    obs_t q_a [$];
    obs_t q_b [$];
    obs_t q_c [$];

    function automatic int h_total(int i);
        return cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
    endfunction

    function automatic int v_total(int i);
        return cfg[i].va + cfg[i].vfp + cfg[i].vs + cfg[i].vbp;
    endfunction

    function automatic obs_t model_out(int i);
        obs_t o;
        cfg_t c;
        int   x, y;
        c = cfg[i];
        o = '0;
        if (rst_st[i]) begin
            o.cd = {~c.vp, ~c.hp};
            return o;
        end
        x     = pres[i] % h_total(i);
        y     = pres[i] / h_total(i);
        o.hc  = 11'(x);
        o.vc  = 10'(y);
        o.vde = (x < c.ha) && (y < c.va);
        o.cd[0] = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
        o.cd[1] = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
        o.ls  = (x == 0);
        o.fs  = (x == 0) && (y == 0);
        o.fc  = 16'(frames[i]);
        o.fsw = ((frames[i] / c.div) % 2) == 1;
        return o;
    endfunction

    function automatic obs_t sample(int i);
        obs_t o;
        o = '0;
        case (i)
            0: begin
                o.hc = vt_a.hcount; o.vc = vt_a.vcount; o.vde = vt_a.VDE; o.cd = vt_a.CD;
                o.ls = vt_a.line_start; o.fs = vt_a.frame_start;
                o.fsw = vt_a.frame_switch; o.fc = vt_a.frame_count;
            end
            1: begin
                o.hc = vt_b.hcount; o.vc = vt_b.vcount; o.vde = vt_b.VDE; o.cd = vt_b.CD;
                o.ls = vt_b.line_start; o.fs = vt_b.frame_start;
                o.fsw = vt_b.frame_switch; o.fc = vt_b.frame_count;
            end
            default: begin
                o.hc = 11'(vt_c.hcount); o.vc = 10'(vt_c.vcount); o.vde = vt_c.VDE; o.cd = vt_c.CD;
                o.ls = vt_c.line_start; o.fs = vt_c.frame_start;
                o.fsw = vt_c.frame_switch; o.fc = vt_c.frame_count;
            end
        endcase
        return o;
    endfunction

    // Drive one edge's inputs and queue the state every generator must
    // present after that edge.
    task automatic step(input bit rst_v, input bit ce_v);
        obs_t o;
        @(negedge clk);
        rst_n   = rst_v;
        vt_a.ce = ce_v;
        vt_b.ce = ce_v;
        vt_c.ce = ce_v;
        for (int i = 0; i < 3; i++) begin
            if (!rst_v) begin
                rst_st[i] = 1'b1;
                pres[i]   = 0;
                nxt[i]    = 0;
                frames[i] = 0;
            end else if (ce_v) begin
                if (!rst_st[i] && pres[i] == h_total(i) * v_total(i) - 1)
                    frames[i]++;
                pres[i]   = nxt[i];
                nxt[i]    = (nxt[i] + 1) % (h_total(i) * v_total(i));
                rst_st[i] = 1'b0;
            end
            o = model_out(i);
            case (i)
                0:       q_a.push_back(o);
                1:       q_b.push_back(o);
                default: q_c.push_back(o);
            endcase
        end
    endtask

    // ---------------------------------------------------------------- monitor
    bit   phase1 = 1'b0;
    int   cyc = 0;
    int   a_hs_low = 0;
    int   a_ls_cyc [2];
    int   a_ls_n = 0;
    int   a_vde_fall = -1;
    logic a_vde_prev = 1'b0;
    logic [4:0] b_fsw_bits = '0;
    int   b_fs_n = 0;
    logic [3:0] c_fsw_bits = '0;
    int   c_fs_n = 0;

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                case (i)
                    0:       if (q_a.size() > 0) begin e = q_a.pop_front(); check($sformatf("dutA_cyc%0d", cyc), sample(0), e); end
                    1:       if (q_b.size() > 0) begin e = q_b.pop_front(); check($sformatf("dutB_cyc%0d", cyc), sample(1), e); end
                    default: if (q_c.size() > 0) begin e = q_c.pop_front(); check($sformatf("dutC_cyc%0d", cyc), sample(2), e); end
                endcase
            end
            if (phase1) begin
                if (vt_a.vcount == 0 && vt_a.CD[0] == 1'b0) a_hs_low++;
                if (vt_a.line_start && a_ls_n < 2) begin
                    a_ls_cyc[a_ls_n] = cyc;
                    a_ls_n++;
                end
                if (a_vde_prev && !vt_a.VDE && a_vde_fall < 0) a_vde_fall = int'(vt_a.hcount);
                a_vde_prev = vt_a.VDE;
                if (vt_b.frame_start && b_fs_n < 5) begin
                    b_fsw_bits[b_fs_n] = vt_b.frame_switch;
                    b_fs_n++;
                end
                if (vt_c.frame_start && c_fs_n < 4) begin
                    c_fsw_bits[c_fs_n] = vt_c.frame_switch;
                    c_fs_n++;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        bit reached;
        cfg[0] = '{ha:800, hfp:40, hs:128, hbp:88, va:600, vfp:1, vs:4, vbp:23, div:11, hp:1'b0, vp:1'b0};
        cfg[1] = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1, div:2, hp:1'b1, vp:1'b1};
        cfg[2] = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1, div:1, hp:1'b1, vp:1'b1};
        vt_a.ce = 1'b0;
        vt_b.ce = 1'b0;
        vt_c.ce = 1'b0;

        // Reset for five edges, then free-run: three default lines, many small frames.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
        phase1 = 1'b1;
        for (int k = 0; k < 3300; k++) step(1'b1, 1'b1);
        @(posedge clk);
        #2;
        phase1 = 1'b0;

        check("a_hsync_low_cycles_line0", 64'(a_hs_low), 64'd128);
        check("a_line_period", 64'(a_ls_cyc[1] - a_ls_cyc[0]), 64'd1056);
        check("a_vde_fall_hcount", 64'(a_vde_fall), 64'd800);
        check("b_frame_switch_seq", 64'(b_fsw_bits), 64'b01100);
        check("c_frame_switch_seq", 64'(c_fsw_bits), 64'b1010);

        // Fixed 1,0,0,1 ce pattern.
        for (int k = 0; k < 240; k++) step(1'b1, (k % 4 == 0) || (k % 4 == 3));

        // Random ce with occasional reset, including resets during stalls.
        for (int k = 0; k < 2000; k++)
            step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)));

        // Reset during B's sync pulse at (5,4), with ce low on the reset edge.
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            if (!rst_st[1] && pres[1] == 4 * h_total(1) + 5) reached = 1'b1;
            else step(1'b1, 1'b1);
        end
        check("b_reset_point_within_bound", 64'(reached), 64'd1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 120; k++) step(1'b1, 1'b1);

        @(posedge clk);
        #2;
        check("queues_drained", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
